rgmii_tx_framer: RTL and testbench

//  Parametrised RGMII transmit framer, single clock domain. Takes a byte stream (valid/ready/last),

---
 rtl/rgmii_tx_framer.sv | 225 ++++++++++++++++++++++
 tb/tb_rgmii_tx_framer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_framer.sv
// rgmii_tx_framer
//   RGMII transmit framer, single clock domain. Turns a valid/ready/last byte stream into
//   preamble + SFD + payload (zero-padded to a minimum length) followed by an inter-frame gap.
//   An underrun mid-frame is reported as TX_ER and the rest of the frame is discarded.
//   Outputs are rise/fall nibble + ctl pairs for downstream ODDR cells.
// Ports
//   clk, rst_n      transmit clock, asynchronous active-low reset
//   mode_gbe        1 = 1000 DDR byte mode, 0 = 10/100 nibble mode (latched at frame start)
//   tick            slot strobe; the framer only advances on cycles where tick is high
//   s_data/s_valid/s_last/s_ready   payload stream
//   txd_rise/txd_fall, ctl_rise/ctl_fall   RGMII data and control pairs
//   busy            framer is not idle
//   underrun        one-cycle pulse when a payload byte was missing at its slot
//   frame_count     frames completed without error, wraps
module rgmii_tx_framer #(
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_BYTES       = 12,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_gbe,
    input  logic             tick,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [3:0]       txd_rise,
    output logic [3:0]       txd_fall,
    output logic             ctl_rise,
    output logic             ctl_fall,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] frame_count
);
    localparam int unsigned LEN_W    = $clog2(MIN_FRAME_BYTES + 1);
    localparam int unsigned SLOT_MAX = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
    localparam int unsigned SLOT_W   = $clog2(SLOT_MAX + 1);
    localparam logic [LEN_W-1:0]  LEN_MIN  = LEN_W'(MIN_FRAME_BYTES);
    localparam logic [SLOT_W-1:0] PRE_LAST = SLOT_W'(PREAMBLE_BYTES - 1);
    localparam logic [SLOT_W-1:0] IFG_LAST = SLOT_W'(IFG_BYTES - 1);

    typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StDrop, StIfg} state_e;

    state_e            state_q;
    logic              gbe_q;
    logic              phase_q;   // nibble mode: 0 = low nibble, 1 = high nibble of the slot
    logic              last_q;
    logic [7:0]        data_q;
    logic [LEN_W-1:0]  len_q;     // payload+pad bytes sent, saturates at LEN_MIN
    logic [SLOT_W-1:0] slot_q;    // completed slots in PRE / IFG

    logic              cur_gbe;
    logic              slot_end;
    logic              accept;
    logic              byte_en;
    logic              byte_err;
    logic [7:0]        byte_v;
    logic [3:0]        nib;
    logic [LEN_W-1:0]  len_inc;

    always_comb begin
        // The frame-start tick already emits the first preamble slot, so use the live mode there.
        cur_gbe  = (state_q == StIdle) ? mode_gbe : gbe_q;
        slot_end = cur_gbe | phase_q;
        len_inc  = (len_q == LEN_MIN) ? len_q : len_q + 1'b1;
        s_ready  = (state_q == StDrop) | ((state_q == StData) & tick & (gbe_q | ~phase_q));
        accept   = s_valid & s_ready;
        busy     = (state_q != StIdle);

        byte_v   = 8'h00;
        byte_en  = 1'b0;
        byte_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    byte_v  = 8'h55;
                    byte_en = 1'b1;
                end
            end
            StPre: begin
                byte_v  = 8'h55;
                byte_en = 1'b1;
            end
            StSfd: begin
                byte_v  = 8'hD5;
                byte_en = 1'b1;
            end
            StData: begin
                if (!gbe_q && phase_q) begin
                    byte_v  = data_q;
                    byte_en = 1'b1;
                end else if (s_valid) begin
                    byte_v  = s_data;
                    byte_en = 1'b1;
                end else begin
                    byte_err = 1'b1;
                end
            end
            StPad: begin
                byte_en = 1'b1;
            end
            default: begin
                byte_v = 8'h00;
            end
        endcase
        nib = phase_q ? byte_v[7:4] : byte_v[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gbe_q       <= 1'b0;
            phase_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= 8'h00;
            len_q       <= '0;
            slot_q      <= '0;
            txd_rise    <= 4'h0;
            txd_fall    <= 4'h0;
            ctl_rise    <= 1'b0;
            ctl_fall    <= 1'b0;
            underrun    <= 1'b0;
            frame_count <= '0;
        end else begin
            underrun <= 1'b0;
            if (tick) begin
                txd_rise <= cur_gbe ? byte_v[3:0] : nib;
                txd_fall <= cur_gbe ? byte_v[7:4] : nib;
                ctl_rise <= byte_en | byte_err;
                ctl_fall <= byte_en;
                if (state_q != StIdle) begin
                    phase_q <= cur_gbe ? 1'b0 : ~phase_q;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (tick && s_valid) begin
                        state_q <= StPre;
                        gbe_q   <= mode_gbe;
                        phase_q <= ~mode_gbe;
                        last_q  <= 1'b0;
                        len_q   <= '0;
                        slot_q  <= mode_gbe ? SLOT_W'(1) : '0;
                    end
                end
                StPre: begin
                    if (tick && slot_end) begin
                        if (slot_q == PRE_LAST) begin
                            state_q <= StSfd;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                StSfd: begin
                    if (tick && slot_end) begin
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (accept) begin
                        data_q <= s_data;
                        last_q <= s_last;
                        len_q  <= len_inc;
                        if (gbe_q && s_last) begin
                            slot_q <= '0;
                            if (len_inc == LEN_MIN) begin
                                state_q     <= StIfg;
                                frame_count <= frame_count + 1'b1;
                            end else begin
                                state_q <= StPad;
                            end
                        end
                    end else if (tick && (gbe_q || !phase_q)) begin
                        // Slot began with no byte available: error slot, then discard.
                        underrun <= 1'b1;
                        phase_q  <= 1'b0;
                        state_q  <= StDrop;
                    end else if (tick && last_q) begin
                        // Nibble mode: last byte's high nibble just went out.
                        slot_q <= '0;
                        if (len_q == LEN_MIN) begin
                            state_q     <= StIfg;
                            frame_count <= frame_count + 1'b1;
                        end else begin
                            state_q <= StPad;
                        end
                    end
                end
                StPad: begin
                    if (tick && slot_end) begin
                        len_q <= len_inc;
                        if (len_inc == LEN_MIN) begin
                            state_q     <= StIfg;
                            slot_q      <= '0;
                            frame_count <= frame_count + 1'b1;
                        end
                    end
                end
                StDrop: begin
                    if (s_valid && s_last) begin
                        state_q <= StIfg;
                        slot_q  <= '0;
                        phase_q <= 1'b0;
                    end
                end
                StIfg: begin
                    if (tick && slot_end) begin
                        if (slot_q == IFG_LAST) begin
                            state_q <= StIdle;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
module tb_rgmii_tx_framer;
    localparam int PRE = 7;
    localparam int MINB = 60;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_gbe = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [3:0]  txd_rise;
    logic [3:0]  txd_fall;
    logic        ctl_rise;
    logic        ctl_fall;
    logic        busy;
    logic        underrun;
    logic [15:0] frame_count;

    rgmii_tx_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_gbe    (mode_gbe),
        .tick        (tick),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .txd_rise    (txd_rise),
        .txd_fall    (txd_fall),
        .ctl_rise    (ctl_rise),
        .ctl_fall    (ctl_fall),
        .busy        (busy),
        .underrun    (underrun),
        .frame_count (frame_count)
    );

    always #4 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          tick_div = 1;
    int          tick_cnt = 0;
    logic        tick_d = 1'b0;
    logic        cap_en = 1'b0;
    int          ur_cnt = 0;
    logic [9:0]  cap_q[$];
    logic [9:0]  exp_q[$];
    logic [7:0]  pl_q[$];
    logic [15:0] exp_fc = 16'd0;

    // Slot strobe: every cycle, or one cycle in tick_div.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_div <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (tick_cnt == 0);
                tick_cnt = (tick_cnt + 1) % tick_div;
            end
        end
    end

    always @(posedge clk) tick_d <= tick;

    // One record per tick: {ctl_rise, ctl_fall, txd_rise, txd_fall}.
    always @(negedge clk) begin
        if (cap_en) begin
            if (tick_d) cap_q.push_back({ctl_rise, ctl_fall, txd_rise, txd_fall});
            if (underrun) ur_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void exp_slot(input logic [7:0] b, input bit en, input bit err,
                                     input bit gbe);
        logic       cr;
        logic       cf;
        logic [7:0] v;
        cr = en | err;
        cf = en & ~err;
        v  = (en && !err) ? b : 8'h00;
        if (gbe) begin
            exp_q.push_back({cr, cf, v[3:0], v[7:4]});
        end else begin
            exp_q.push_back({cr, cf, v[3:0], v[3:0]});
            exp_q.push_back({cr, cf, v[7:4], v[7:4]});
        end
    endfunction

    // Expected slots for payload pl_q; err_at >= 0 means the byte at that index is missing.
    function automatic void exp_frame(input bit gbe, input int err_at);
        for (int i = 0; i < PRE; i++) exp_slot(8'h55, 1'b1, 1'b0, gbe);
        exp_slot(8'hD5, 1'b1, 1'b0, gbe);
        if (err_at >= 0) begin
            for (int i = 0; i < err_at; i++) exp_slot(pl_q[i], 1'b1, 1'b0, gbe);
            exp_slot(8'h00, 1'b0, 1'b1, gbe);
        end else begin
            for (int i = 0; i < pl_q.size(); i++) exp_slot(pl_q[i], 1'b1, 1'b0, gbe);
            for (int i = pl_q.size(); i < MINB; i++) exp_slot(8'h00, 1'b1, 1'b0, gbe);
        end
        for (int i = 0; i < IFG; i++) exp_slot(8'h00, 1'b0, 1'b0, gbe);
    endfunction

    // ---------------- helpers ----------------
    task automatic start_capture();
        cap_q.delete();
        exp_q.delete();
        ur_cnt = 0;
        cap_en = 1'b1;
    endtask

    task automatic random_payload(input int len);
        pl_q.delete();
        for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
    endtask

    task automatic send_frame(input int gap_at, input int gap_len, input bit keep_valid);
        int  i = 0;
        int  budget = 20000;
        bit  gapped = 1'b0;
        logic hs;
        while (i < pl_q.size() && budget > 0) begin
            if (i == gap_at && !gapped) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
                repeat (gap_len - 1) @(negedge clk);
                gapped = 1'b1;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = pl_q[i];
            s_last  = (i == pl_q.size() - 1);
            #1;
            hs = s_ready;
            @(posedge clk);
            if (hs) i++;
            budget--;
        end
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: sent %0d of %0d bytes", i, pl_q.size());
        end
        if (!keep_valid) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        @(negedge clk);
        while (busy && b < 20000) begin
            @(negedge clk);
            b++;
        end
        n_tests++;
        if (b >= 20000) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, b);
        end
        repeat (4 * tick_div + 2) @(negedge clk);
        cap_en = 1'b0;
    endtask

    task automatic check_stream(input string name);
        int s = 0;
        int bad = -1;
        while (s < cap_q.size() && cap_q[s] == 10'h000) s++;
        n_tests++;
        if (cap_q.size() - s < exp_q.size()) begin
            n_fail++;
            $display("FAIL %s length: got %0d slots, required at least %0d", name,
                     cap_q.size() - s, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (cap_q[s + i] !== exp_q[i]) begin
                    bad = i;
                    break;
                end
            end
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s slot %0d: got %h required %h", name, bad, cap_q[s + bad],
                         exp_q[bad]);
            end
        end
    endtask

    task automatic check_fc(input string name);
        n_tests++;
        if (frame_count !== exp_fc) begin
            n_fail++;
            $display("FAIL %s frame_count: got %0d required %0d", name, frame_count, exp_fc);
        end
    endtask

    task automatic check_ur(input string name, input int want);
        n_tests++;
        if (ur_cnt !== want) begin
            n_fail++;
            $display("FAIL %s underrun cycles: got %0d required %0d", name, ur_cnt, want);
        end
    endtask

    task automatic check_quiet(input string name);
        n_tests++;
        if ({txd_rise, txd_fall, ctl_rise, ctl_fall, busy, underrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL %s outputs: got txd=%h/%h ctl=%b%b busy=%b ur=%b required all 0",
                     name, txd_rise, txd_fall, ctl_rise, ctl_fall, busy, underrun);
        end
        check_fc(name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset_released");
        n_tests++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_s_ready: got %b required 0", s_ready);
        end
    endtask

    task automatic test_gbe_basic();
        start_capture();
        pl_q.delete();
        pl_q.push_back(8'h01);
        pl_q.push_back(8'h02);
        pl_q.push_back(8'h03);
        send_frame(-1, 0, 1'b0);
        wait_idle();
        exp_frame(1'b1, -1);
        exp_fc++;
        check_stream("gbe_basic");
        check_fc("gbe_basic");
        check_ur("gbe_basic", 0);
    endtask

    task automatic test_gbe_lengths();
        int lens[6];
        lens[0] = MINB - 1;
        lens[1] = MINB;
        lens[2] = MINB + 1;
        lens[3] = 64;
        lens[4] = $urandom_range(1, 58);
        lens[5] = $urandom_range(62, 100);
        for (int k = 0; k < 6; k++) begin
            start_capture();
            random_payload(lens[k]);
            send_frame(-1, 0, 1'b0);
            wait_idle();
            exp_frame(1'b1, -1);
            exp_fc++;
            check_stream($sformatf("gbe_len%0d", lens[k]));
            check_fc($sformatf("gbe_len%0d", lens[k]));
        end
    endtask

    task automatic test_nibble();
        tick_div = 5;
        mode_gbe = 1'b0;
        repeat (10) @(negedge clk);
        start_capture();
        random_payload(4);
        pl_q[0] = 8'hA5;
        fork
            send_frame(-1, 0, 1'b0);
            begin
                // Mode flip mid-frame must be ignored.
                repeat (150) @(negedge clk);
                mode_gbe = 1'b1;
            end
        join
        wait_idle();
        exp_frame(1'b0, -1);
        exp_fc++;
        check_stream("nibble");
        check_fc("nibble");
        tick_div = 1;
        mode_gbe = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_underrun();
        int len;
        int gap;
        for (int k = 0; k < 2; k++) begin
            len = $urandom_range(20, 40);
            gap = (k == 0) ? 10 : $urandom_range(1, len - 2);
            start_capture();
            random_payload(len);
            send_frame(gap, 3, 1'b0);
            wait_idle();
            exp_frame(1'b1, gap);
            check_stream($sformatf("underrun_at%0d", gap));
            check_ur($sformatf("underrun_at%0d", gap), 1);
            check_fc($sformatf("underrun_at%0d", gap));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f2[$];
        start_capture();
        random_payload($urandom_range(1, 70));
        exp_frame(1'b1, -1);
        send_frame(-1, 0, 1'b1);
        random_payload($urandom_range(1, 70));
        f2 = pl_q;
        exp_frame(1'b1, -1);
        pl_q = f2;
        send_frame(-1, 0, 1'b0);
        wait_idle();
        exp_fc += 16'd2;
        check_stream("back_to_back");
        check_fc("back_to_back");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'b0;
        end
        @(posedge clk);
        #2;
        n_tests++;
        if (busy !== 1'b1 || ctl_rise !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_active: got busy=%b ctl_rise=%b required 1 1", busy,
                     ctl_rise);
        end
        rst_n = 1'b0;
        #1;
        exp_fc = 16'd0;
        check_quiet("reset_mid_async");
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_capture();
        random_payload($urandom_range(1, 80));
        send_frame(-1, 0, 1'b0);
        wait_idle();
        exp_frame(1'b1, -1);
        exp_fc++;
        check_stream("after_reset");
        check_fc("after_reset");
    endtask

    initial begin
        test_reset();
        test_gbe_basic();
        test_gbe_lengths();
        test_nibble();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
